// File: rtl/core_pkg.sv
// Shared core-wide constants for the register file and scoreboard.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PENDING_W  = 6;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Bundle of write-back, operand-read and issue signals between the
// pipeline (master) and the register file / scoreboard (slave).
interface reg_file_scoreboard_if #(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned NREGS = core_pkg::NREGS
);
  import core_pkg::*;

  logic                 wb_we;
  reg_addr_t            wb_rd;
  logic [XLEN-1:0]      wb_data;
  reg_addr_t            rs1_addr;
  reg_addr_t            rs2_addr;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;
  logic                 issue_valid;
  logic                 issue_we;
  reg_addr_t            issue_rd;
  logic                 stall;
  logic [NREGS-1:0]     busy;
  logic [PENDING_W-1:0] pending_count;

  modport master (
    output wb_we, wb_rd, wb_data, rs1_addr, rs2_addr,
    output issue_valid, issue_we, issue_rd,
    input  rs1_data, rs2_data, stall, busy, pending_count
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, rs1_addr, rs2_addr,
    input  issue_valid, issue_we, issue_rd,
    output rs1_data, rs2_data, stall, busy, pending_count
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks in-flight destinations, raises stall on
// RAW/WAW hazards, and keeps a registered count of busy registers.
module reg_scoreboard #(
  parameter int unsigned NREGS = core_pkg::NREGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wb_we,
  input  core_pkg::reg_addr_t            wb_rd,
  input  core_pkg::reg_addr_t            rs1_addr,
  input  core_pkg::reg_addr_t            rs2_addr,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  core_pkg::reg_addr_t            issue_rd,
  output logic                           stall,
  output logic [NREGS-1:0]               busy,
  output logic [core_pkg::PENDING_W-1:0] pending_count
);
  import core_pkg::*;

  logic [NREGS-1:0]     busy_q;
  logic [NREGS-1:0]     busy_nxt;
  logic [NREGS-1:0]     clr_vec;
  logic [NREGS-1:0]     set_vec;
  logic [NREGS-1:0]     hz_vec;
  logic [PENDING_W-1:0] count_q;
  logic [PENDING_W-1:0] count_nxt;
  logic                 accepted;

  // Per-register clear and hazard terms; x0 never clears and never hazards.
  always_comb begin
    clr_vec = '0;
    hz_vec  = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      clr_vec[r] = wb_we && (wb_rd == REG_ADDR_W'(r));
      hz_vec[r]  = busy_q[r] && !clr_vec[r];
    end
  end

  // Decode stall: a same-cycle write-back releases the hazard via clr.
  always_comb begin
    stall    = issue_valid &&
               (hz_vec[rs1_addr] || hz_vec[rs2_addr] || (issue_we && hz_vec[issue_rd]));
    accepted = issue_valid && !stall;
  end

  // Next busy vector (set wins over clear) and its popcount.
  always_comb begin
    set_vec   = '0;
    busy_nxt  = busy_q;
    count_nxt = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      set_vec[r] = accepted && issue_we && (issue_rd == REG_ADDR_W'(r));
      if (set_vec[r])
        busy_nxt[r] = 1'b1;
      else if (clr_vec[r])
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++)
      count_nxt = count_nxt + PENDING_W'(busy_nxt[r]);
  end

  // Scoreboard state register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_nxt;
      count_q <= count_nxt;
    end
  end

  assign busy          = busy_q;
  assign pending_count = count_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-through bypass reads, plus the
// pending-write scoreboard that drives decode stall.
module reg_file_scoreboard #(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned NREGS = core_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_scoreboard_if.slave  bus
);
  import core_pkg::*;

  logic [XLEN-1:0] regs [NREGS];

  // Register array write; x0 writes are dropped so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_rd != REG_ZERO) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Operand reads: x0 is zero, same-cycle write-back is bypassed, and the
  // whole file reads as cleared while reset is held.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (!rst && bus.rs1_addr != REG_ZERO)
      bus.rs1_data = (bus.wb_we && bus.wb_rd == bus.rs1_addr) ? bus.wb_data
                                                              : regs[bus.rs1_addr];
    if (!rst && bus.rs2_addr != REG_ZERO)
      bus.rs2_data = (bus.wb_we && bus.wb_rd == bus.rs2_addr) ? bus.wb_data
                                                              : regs[bus.rs2_addr];
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .wb_we         (bus.wb_we),
    .wb_rd         (bus.wb_rd),
    .rs1_addr      (bus.rs1_addr),
    .rs2_addr      (bus.rs2_addr),
    .issue_valid   (bus.issue_valid),
    .issue_we      (bus.issue_we),
    .issue_rd      (bus.issue_rd),
    .stall         (bus.stall),
    .busy          (bus.busy),
    .pending_count (bus.pending_count)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed-vector bench for reg_file_scoreboard with hand-computed expectations.
module tb_reg_file_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard_if #(.XLEN(32), .NREGS(32)) bus ();

  reg_file_scoreboard #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock: inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rd    = '0;
  endtask

  initial begin
    idle();

    // Reset: held for two edges, then every address reads zero.
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 32'h0);
    check("rst_pending", 32'(bus.pending_count), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    for (int unsigned a = 0; a < 32; a++) begin
      bus.rs1_addr = 5'(a);
      bus.rs2_addr = 5'(31 - a);
      #0.1;
      check("rst_rs1", bus.rs1_data, 32'h0);
      check("rst_rs2", bus.rs2_data, 32'h0);
    end
    idle();
    tick();

    // Write/read with bypass, then from the array next cycle.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    #1;
    check("wr_bypass_rs1", bus.rs1_data, 32'hDEADBEEF);
    check("wr_other_rs2", bus.rs2_data, 32'h0);
    tick();
    bus.wb_we = 1'b0; bus.wb_data = 32'h0;
    #1;
    check("wr_array_rs1", bus.rs1_data, 32'hDEADBEEF);
    check("wr_nonbusy_busy", bus.busy, 32'h0);
    check("wr_nonbusy_pending", 32'(bus.pending_count), 32'd0);
    // Write to x0 is dropped.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h12345678;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    #1;
    check("x0_bypass_rs1", bus.rs1_data, 32'h0);
    tick();
    bus.wb_we = 1'b0;
    #1;
    check("x0_array_rs2", bus.rs2_data, 32'h0);
    idle();

    // RAW: issue rd=7, then a consumer of x7 stalls until write-back.
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd7;
    #1;
    check("raw_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.issue_rd = 5'd8; bus.rs2_addr = 5'd7;
    #1;
    check("raw_busy", bus.busy, 32'h0000_0080);
    check("raw_pending", 32'(bus.pending_count), 32'd1);
    check("raw_stall_c1", 32'(bus.stall), 32'd1);
    tick();
    check("raw_stall_c2", 32'(bus.stall), 32'd1);
    check("raw_held_busy", bus.busy, 32'h0000_0080);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hCAFEF00D;
    #1;
    check("raw_release_stall", 32'(bus.stall), 32'd0);
    check("raw_bypass_rs2", bus.rs2_data, 32'hCAFEF00D);
    tick();
    idle();
    #1;
    check("raw_after_busy", bus.busy, 32'h0000_0100);
    check("raw_after_pending", 32'(bus.pending_count), 32'd1);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd8; bus.wb_data = 32'h8;
    tick();
    idle();
    check("raw_drain_busy", bus.busy, 32'h0);

    // WAW with simultaneous set and clear of x3.
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd3;
    tick();
    check("waw_busy_pre", bus.busy, 32'h0000_0008);
    check("waw_pending_pre", 32'(bus.pending_count), 32'd1);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
    #1;
    check("waw_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    check("waw_busy_post", bus.busy, 32'h0000_0008);
    check("waw_pending_post", 32'(bus.pending_count), 32'd1);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h34;
    tick();
    idle();
    check("waw_drain_pending", 32'(bus.pending_count), 32'd0);

    // Occupancy: fill x1..x31 back-to-back.
    for (int unsigned r = 1; r < 32; r++) begin
      bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'(r);
      tick();
    end
    idle();
    #1;
    check("occ_full_pending", 32'(bus.pending_count), 32'd31);
    check("occ_full_busy", bus.busy, 32'hFFFF_FFFE);
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd0;
    #1;
    check("occ_x0_stall", 32'(bus.stall), 32'd0);
    bus.rs1_addr = 5'd12;
    #1;
    check("occ_rs1_stall", 32'(bus.stall), 32'd1);
    idle();
    // Retire in reverse order.
    for (int unsigned r = 31; r >= 1; r--) begin
      bus.wb_we = 1'b1; bus.wb_rd = 5'(r); bus.wb_data = 32'h100 + r;
      tick();
      check("occ_retire_pending", 32'(bus.pending_count), r - 1);
    end
    // Extra write-back to non-busy x9.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h9999;
    tick();
    idle();
    #1;
    check("occ_extra_pending", 32'(bus.pending_count), 32'd0);
    check("occ_extra_busy", bus.busy, 32'h0);
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd31;
    #1;
    check("occ_x9_data", bus.rs1_data, 32'h9999);
    check("occ_x31_data", bus.rs2_data, 32'h11F);
    idle();

    // Async reset mid-flight with four busy registers.
    for (int unsigned r = 1; r <= 4; r++) begin
      bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'(r);
      tick();
    end
    idle();
    #1;
    check("ar_pending_pre", 32'(bus.pending_count), 32'd4);
    bus.rs1_addr = 5'd9;
    #2 rst = 1'b1;
    #1;
    check("ar_busy", bus.busy, 32'h0);
    check("ar_pending", 32'(bus.pending_count), 32'd0);
    check("ar_rs1_zero", bus.rs1_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    // Late write-back to x2 writes the file but cannot underflow.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hA5A5_0002;
    tick();
    idle();
    bus.rs1_addr = 5'd2;
    #1;
    check("ar_late_pending", 32'(bus.pending_count), 32'd0);
    check("ar_late_busy", bus.busy, 32'h0);
    check("ar_late_data", bus.rs1_data, 32'hA5A5_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
